// File: rtl/conv_window_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution window sequencer:
//   ctrl_state_t   - sequencer state encoding
//   SEL_TL..SEL_BR - pixel matrix 3x3 window select codes
//   WIN_PER_BLOCK  - number of 3x3 sub-windows in one 4x4 block
// ---------------------------------------------------------------------------
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_BUF = 3'd1,
        LOAD     = 3'd2,
        ISSUE    = 3'd3,
        NEXT     = 3'd4,
        DONE     = 3'd5
    } ctrl_state_t;

    // Window select codes; bit 1 picks rows 1-3, bit 0 picks cols 1-3.
    localparam logic [1:0] SEL_TL = 2'b00;
    localparam logic [1:0] SEL_TR = 2'b01;
    localparam logic [1:0] SEL_BL = 2'b10;
    localparam logic [1:0] SEL_BR = 2'b11;

    localparam int WIN_PER_BLOCK = 4;

    // The bottom-right window is always the last one handed out per block.
    function automatic logic is_last_window(input logic [1:0] win);
        return win == SEL_BR;
    endfunction

endpackage

// File: rtl/conv_window_ctrl_if.sv
// ---------------------------------------------------------------------------
// conv_window_ctrl_if
// Handshake bundle between the window sequencer and its datapath neighbours.
//   buffer_valid - line buffer holds a complete 4x4 block
//   buffer_ack   - block consumed, line buffer may advance
//   load_enable  - pixel matrix load strobe
//   select       - pixel matrix 3x3 window select
//   conv_valid   - window presented to the convolution unit
//   conv_ready   - convolution unit accepts the window
// master = sequencer side, slave = datapath side.
// ---------------------------------------------------------------------------
interface conv_window_ctrl_if;

    logic       buffer_valid;
    logic       buffer_ack;
    logic       load_enable;
    logic [1:0] select;
    logic       conv_valid;
    logic       conv_ready;

    modport master (
        input  buffer_valid,
        input  conv_ready,
        output buffer_ack,
        output load_enable,
        output select,
        output conv_valid
    );

    modport slave (
        output buffer_valid,
        output conv_ready,
        input  buffer_ack,
        input  load_enable,
        input  select,
        input  conv_valid
    );

endinterface

// File: rtl/conv_window_ctrl_counter.sv
// ---------------------------------------------------------------------------
// flex_counter
// Generic up counter with synchronous clear and programmable rollover.
//   clk, n_rst     - clock, asynchronous active-low reset
//   clear          - synchronous clear to zero (wins over count_enable)
//   count_enable   - advance by one
//   rollover_val   - last value before wrapping back to zero
//   count_out      - current count
//   rollover_flag  - count_out equals rollover_val
// ---------------------------------------------------------------------------
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count_q;
    logic [NUM_CNT_BITS-1:0] count_d;

    // Clear has priority so a caller can hold the count at zero while idle.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            count_d = (count_q == rollover_val) ? '0 : count_q + NUM_CNT_BITS'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out     = count_q;
    assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/conv_window_ctrl.sv
// ---------------------------------------------------------------------------
// conv_window_ctrl
// Sequences 4x4 pixel blocks through the 3x3 convolution unit: waits for the
// line buffer, pulses the matrix load, then hands out the four sub-windows
// (TL, TR, BL, BR) under a valid/ready handshake. Counts blocks per frame
// and pulses frame_done after the last window of the last block.
//   clk, n_rst  - clock, asynchronous active-low reset
//   start       - begin a frame (honoured only when idle)
//   abort       - synchronous abort back to idle, overrides everything
//   win_if      - line buffer / pixel matrix / convolution handshake
//   busy        - high whenever not idle
//   block_idx   - index of the current block in the frame
//   frame_done  - one-cycle pulse at frame completion
// ---------------------------------------------------------------------------
module conv_window_ctrl
    import conv_pkg::*;
#(
    parameter int NUM_BLOCKS = 16,
    parameter int BW         = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      start,
    input  logic                      abort,
    conv_window_ctrl_if.master        win_if,
    output logic                      busy,
    output logic [BW-1:0]             block_idx,
    output logic                      frame_done
);

    localparam logic [BW-1:0] LAST_IDX = BW'(NUM_BLOCKS - 1);

    ctrl_state_t state_q, state_d;
    logic [1:0]  win_cnt_q, win_cnt_d;

    logic        busy_q, busy_d;
    logic        load_q, load_d;
    logic        conv_valid_q, conv_valid_d;
    logic [1:0]  select_q, select_d;
    logic        frame_done_q, frame_done_d;

    logic        last_block;
    logic        accept;
    logic        blk_clear;
    logic        blk_enable;

    assign accept = conv_valid_q & win_if.conv_ready;

    // Next-state and window counter. Abort forces idle from anywhere; the
    // window counter only moves on an accepted window and stops at BR.
    always_comb begin
        state_d   = state_q;
        win_cnt_d = win_cnt_q;
        if (abort) begin
            state_d   = IDLE;
            win_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    win_cnt_d = '0;
                    if (start) begin
                        state_d = WAIT_BUF;
                    end
                end
                WAIT_BUF: begin
                    if (win_if.buffer_valid) begin
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    win_cnt_d = '0;
                    state_d   = ISSUE;
                end
                ISSUE: begin
                    if (accept) begin
                        if (is_last_window(win_cnt_q)) begin
                            state_d = NEXT;
                        end else begin
                            win_cnt_d = win_cnt_q + 2'd1;
                        end
                    end
                end
                NEXT: begin
                    state_d = last_block ? DONE : WAIT_BUF;
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d   = IDLE;
                    win_cnt_d = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the upcoming state so that, once registered,
    // they line up exactly with the state they belong to.
    always_comb begin
        busy_d       = (state_d != IDLE);
        load_d       = (state_d == LOAD);
        conv_valid_d = (state_d == ISSUE);
        select_d     = (state_d == ISSUE) ? win_cnt_d : SEL_TL;
        frame_done_d = (state_d == DONE);
    end

    // State, window counter and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            win_cnt_q    <= '0;
            busy_q       <= 1'b0;
            load_q       <= 1'b0;
            conv_valid_q <= 1'b0;
            select_q     <= SEL_TL;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_cnt_q    <= win_cnt_d;
            busy_q       <= busy_d;
            load_q       <= load_d;
            conv_valid_q <= conv_valid_d;
            select_q     <= select_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Block counter clears on entry to idle (covers abort and frame end),
    // and never advances past the last block.
    assign blk_clear  = (state_d == IDLE);
    assign blk_enable = (state_q == NEXT) && !last_block && !abort;

    flex_counter #(
        .NUM_CNT_BITS (BW)
    ) u_block_cnt (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (blk_clear),
        .count_enable  (blk_enable),
        .rollover_val  (LAST_IDX),
        .count_out     (block_idx),
        .rollover_flag (last_block)
    );

    assign busy               = busy_q;
    assign frame_done         = frame_done_q;
    assign win_if.load_enable = load_q;
    assign win_if.buffer_ack  = load_q;
    assign win_if.conv_valid  = conv_valid_q;
    assign win_if.select      = select_q;

endmodule

// File: doc/conv_window_ctrl.md
# conv_window_ctrl

Sequencer for the 4x4 pixel matrix feeding the 3x3 convolution unit. For each 4x4 block it waits for the line buffer to present data and pulses the matrix load. It then steps the matrix window select through all four 3x3 sub-windows (00, 01, 10, 11), handing each to the convolution unit under a valid/ready handshake. It counts blocks per frame and flags frame completion. It sits between the line buffer, the pixel matrix and the convolution engine in the top-level datapath.

## Interface
Parameters:
- NUM_BLOCKS, default 16: 4x4 blocks per frame; legal range is 1 or more.
- BW, default $clog2(NUM_BLOCKS) (minimum 1): block counter width.

Ports:
- clk  in  1  system clock. One clock; all state updates on its rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin a frame. Honoured only in IDLE.
- abort  in  1  synchronous abort; overrides all other inputs.
- buffer_valid  in  1  line buffer holds a complete 4x4 block.
- buffer_ack  out  1  block consumed; the line buffer may advance.
- load_enable  out  1  pixel matrix load strobe.
- select  out  2  pixel matrix window select.
- conv_valid  out  1  current 3x3 window is presented to the convolution unit.
- conv_ready  in  1  convolution unit accepts the window.
- busy  out  1  high in every state except IDLE.
- block_idx  out  BW  index of the current block, 0..NUM_BLOCKS-1.
- frame_done  out  1  one-cycle pulse after the last window of the last block.

## Operation
- States:
  - IDLE
  - WAIT_BUF
  - LOAD
  - ISSUE
  - NEXT
  - DONE
- All outputs are Moore outputs, decoded from registered state and counters.
- IDLE: start=1 -> WAIT_BUF. Both counters clear.
- WAIT_BUF: buffer_valid=1 -> LOAD. Otherwise stays.
- LOAD: load_enable=1 and buffer_ack=1 for exactly one cycle; win_cnt=0; unconditional -> ISSUE.
- ISSUE:
  - conv_valid=1; select=win_cnt.
  - An accept is conv_valid&conv_ready. On accept with win_cnt<3: win_cnt+1, stay in ISSUE.
  - On accept with win_cnt=3 -> NEXT.
  - Without accept, select and conv_valid hold stable.
- NEXT:
  - If block_idx=NUM_BLOCKS-1 -> DONE.
  - Otherwise block_idx+1 -> WAIT_BUF.
- DONE: frame_done=1 for one cycle -> IDLE. block_idx clears on entry to IDLE.
- Window order is fixed: 00 (rows 0-2, cols 0-2), 01 (cols 1-3), 10 (rows 1-3), 11 (rows 1-3, cols 1-3).
- Abort: from any state, the next state is IDLE, counters clear, and frame_done is not pulsed. abort wins over start in IDLE.
- start outside IDLE is ignored.
- buffer_valid outside WAIT_BUF is ignored. It is not latched.
- In IDLE, select is driven to 2'b00.
- win_cnt is 2 bits and never wraps past 3 inside ISSUE.
- block_idx saturates at NUM_BLOCKS-1; it is never incremented there.

## Timing
- Reset values of outputs: buffer_ack=0, load_enable=0, select=2'b00, conv_valid=0, busy=0, block_idx=0, frame_done=0. State is IDLE.
- Reset is asynchronous. Deassertion mid-frame yields IDLE with no spurious strobes.
- Frame start, with start at cycle 0 and buffer_valid held high:
  - cycle 1: WAIT_BUF.
  - cycle 2: LOAD.
  - cycles 3-6: ISSUE, select 0,1,2,3, assuming conv_ready is held high.
  - cycle 7: NEXT.
- Matrix data is captured at the end of the LOAD cycle, so the window is valid in the first ISSUE cycle.
- Steady state: 7 cycles per block. WAIT_BUF -> LOAD -> 4x ISSUE -> NEXT.
- Last block: NEXT -> DONE (frame_done) -> IDLE. busy drops in the cycle after DONE.
- conv_ready low stretches ISSUE one cycle per stall. There is no bound.

## Structure
- Shared package conv_pkg holds:
  - state enum ctrl_state_t.
  - window select constants SEL_TL=2'b00, SEL_TR=2'b01, SEL_BL=2'b10, SEL_BR=2'b11.
  - WIN_PER_BLOCK=4.
- The block counter is an instance of the codebase's flex_counter (parameter BW, rollover NUM_BLOCKS-1, clear on IDLE/abort). win_cnt stays inline.

## Test plan
- Reset, then NUM_BLOCKS=2, start, and buffer_valid, conv_ready held high:
  - load_enable at cycles 2 and 9.
  - select sequence 0,1,2,3 per block.
  - frame_done at cycle 15.
  - busy low at 16.
- conv_ready low for 3 cycles while select=2:
  - select stays 2 and conv_valid stays 1 for all 3 cycles.
  - On release, select advances to 3.
- buffer_valid low for 5 cycles in WAIT_BUF: no load_enable or buffer_ack until the cycle after buffer_valid rises.
- abort asserted in ISSUE with select=1: next cycle IDLE, select=0, block_idx=0, conv_valid=0, no frame_done.
- start pulsed during ISSUE, then start together with abort in IDLE: both ignored, frame unaffected.
- n_rst asserted mid-ISSUE: outputs immediately at reset values; after release, normal frame from a new start.
